// File: rtl/rst_seq_gen_pkg.sv
// rst_seq_gen shared types: FSM states, reset-cause codes, counter sizing.
// Optional build macro RST_CAUSE_EN enables the rst_cause output.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    IDLE    = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_SW   = 2'b01;
  localparam logic [1:0] CAUSE_WDT  = 2'b10;
  localparam logic [1:0] CAUSE_BOTH = 2'b11;

  function automatic int cnt_width(
    input int pulse,
    input int tmo
  );
    int m;
    m = (pulse > tmo) ? pulse : tmo;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/rst_seq_gen_if.sv
// Request / ack / staged-reset bundle for rst_seq_gen.
// rst_cause exists only when RST_CAUSE_EN is defined.
interface rst_seq_gen_if #(
  parameter int NUM_STAGES = 4
);

  logic                  sw_req;
  logic                  wdt_req;
  logic [NUM_STAGES-1:0] stage_ack;
  logic [NUM_STAGES-1:0] stage_rst_n;
  logic                  busy;
  logic                  timeout_err;
`ifdef RST_CAUSE_EN
  logic [1:0]            rst_cause;
`endif

  modport master (
    output sw_req,
    output wdt_req,
    output stage_ack,
    input  stage_rst_n,
    input  busy,
    input  timeout_err
`ifdef RST_CAUSE_EN
    ,
    input  rst_cause
`endif
  );

  modport slave (
    input  sw_req,
    input  wdt_req,
    input  stage_ack,
    output stage_rst_n,
    output busy,
    output timeout_err
`ifdef RST_CAUSE_EN
    ,
    output rst_cause
`endif
  );

endinterface

// File: rtl/rst_seq_gen_timer.sv
// Saturating clear/enable counter for rst_seq_gen with gap/timeout compares.
// Unaffected by RST_CAUSE_EN.
module rst_seq_timer
  import rst_seq_pkg::*;
#(
  parameter int PULSE_CYC   = 16,
  parameter int GAP_CYC     = 8,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic [cnt_width(PULSE_CYC, ACK_TIMEOUT)-1:0] cnt_o,
  output logic gap_met_o,
  output logic timeout_hit_o
);

  localparam int CW = cnt_width(PULSE_CYC, ACK_TIMEOUT);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Saturate instead of wrapping so a stuck state never re-fires compares.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o         = cnt_q;
  assign gap_met_o     = (cnt_q >= GAP_LAST);
  assign timeout_hit_o = (cnt_q == TMO_LAST);

endmodule

// File: rtl/rst_seq_gen.sv
// Staged reset sequencer: pulse all resets, then release stages in order.
// Define RST_CAUSE_EN to add the registered rst_cause output.
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int PULSE_CYC   = 16,
  parameter int GAP_CYC     = 8,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  rst_seq_gen_if.slave bus
);

  localparam int NS = NUM_STAGES;
  localparam int CW = cnt_width(PULSE_CYC, ACK_TIMEOUT);
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NS - 1);

  state_e        state_q, state_d;
  logic [NS-1:0] srst_q, srst_d;
  logic          busy_q, busy_d;
  logic          terr_q, terr_d;
  logic [IW-1:0] idx_q, idx_d;
`ifdef RST_CAUSE_EN
  logic [1:0]    cause_q, cause_d;
`endif

  logic [CW-1:0] cnt;
  logic          gap_met;
  logic          timeout_hit;
  logic          cnt_clr;
  logic          cnt_en;
  logic          req;
  logic          ack_ok;
  logic          adv;

  rst_seq_timer #(
    .PULSE_CYC   (PULSE_CYC),
    .GAP_CYC     (GAP_CYC),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_timer (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clr_i         (cnt_clr),
    .en_i          (cnt_en),
    .cnt_o         (cnt),
    .gap_met_o     (gap_met),
    .timeout_hit_o (timeout_hit)
  );

  assign req    = bus.sw_req | bus.wdt_req;
  assign ack_ok = bus.stage_ack[idx_q] & gap_met;
  assign adv    = ack_ok | timeout_hit;

  always_comb begin
    state_d = state_q;
    srst_d  = srst_q;
    busy_d  = busy_q;
    terr_d  = terr_q;
    idx_d   = idx_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
`ifdef RST_CAUSE_EN
    cause_d = cause_q;
`endif
    if (req) begin
      state_d = ASSERT;
      srst_d  = '0;
      busy_d  = 1'b1;
      idx_d   = '0;
      cnt_clr = 1'b1;
`ifdef RST_CAUSE_EN
      unique case (1'b1)
        (bus.sw_req & bus.wdt_req): cause_d = CAUSE_BOTH;
        bus.wdt_req:                cause_d = CAUSE_WDT;
        default:                    cause_d = CAUSE_SW;
      endcase
`endif
    end else begin
      unique case (state_q)
        ASSERT: begin
          if (cnt == PULSE_LAST) begin
            srst_d  = NS'(1);
            idx_d   = '0;
            cnt_clr = 1'b1;
            state_d = RELEASE;
          end else begin
            cnt_en = 1'b1;
          end
        end
        RELEASE: begin
          if (adv) begin
            cnt_clr = 1'b1;
            if (!ack_ok) begin
              terr_d = 1'b1;
            end
            // Thermometer release keeps earlier stages out of reset.
            if (idx_q == IDX_LAST) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              srst_d = (srst_q << 1) | NS'(1);
              idx_d  = idx_q + 1'b1;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
        IDLE: begin
          srst_d = '1;
          busy_d = 1'b0;
        end
        default: begin
          state_d = ASSERT;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ASSERT;
      srst_q  <= '0;
      busy_q  <= 1'b1;
      terr_q  <= 1'b0;
      idx_q   <= '0;
`ifdef RST_CAUSE_EN
      cause_q <= CAUSE_POR;
`endif
    end else begin
      state_q <= state_d;
      srst_q  <= srst_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
      idx_q   <= idx_d;
`ifdef RST_CAUSE_EN
      cause_q <= cause_d;
`endif
    end
  end

  assign bus.stage_rst_n = srst_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;
`ifdef RST_CAUSE_EN
  assign bus.rst_cause   = cause_q;
`endif

endmodule

// File: tb/tb_rst_seq_gen.sv
// Scoreboard bench for rst_seq_gen; release edges queued and matched.
// Extra rst_cause checks compile in when RST_CAUSE_EN is defined.
module tb_rst_seq_gen;

  localparam int NS = 4;
  localparam int PC = 16;
  localparam int GC = 8;
  localparam int AT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rst_seq_gen_if #(.NUM_STAGES(NS)) bus ();

  rst_seq_gen #(
    .NUM_STAGES  (NS),
    .PULSE_CYC   (PC),
    .GAP_CYC     (GC),
    .ACK_TIMEOUT (AT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    int            c;
    logic [NS-1:0] v;
    bit            chk_b;
    logic          b;
  } ev_t;

  ev_t           exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  bit            mon_en = 1'b0;
  logic [NS-1:0] prev;

  // Every change of stage_rst_n must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mon_en && (bus.stage_rst_n !== prev)) begin
      ev_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_edge: cyc %0d rst_n %b, none expected",
                 cyc, bus.stage_rst_n);
      end else begin
        e = exp_q.pop_front();
        if ((cyc !== e.c) || (bus.stage_rst_n !== e.v) ||
            (e.chk_b && (bus.busy !== e.b))) begin
          n_bad++;
          $display({"FAIL release_edge: got cyc %0d rst_n %b busy %b,",
                    " want cyc %0d rst_n %b busy %b"},
                   cyc, bus.stage_rst_n, bus.busy, e.c, e.v, e.b);
        end
      end
      prev = bus.stage_rst_n;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push(input int c, input logic [NS-1:0] v,
                      input bit cb, input logic b);
    ev_t e;
    e.c = c;
    e.v = v;
    e.chk_b = cb;
    e.b = b;
    exp_q.push_back(e);
  endtask

  // Expected edges for a clean run whose ASSERT entry edge is s.
  task automatic push_seq(input int s, input bit first);
    logic [NS-1:0] v;
    v = '0;
    if (first) push(s, '0, 1'b1, 1'b1);
    for (int k = 0; k < NS; k++) begin
      v = (v << 1) | NS'(1);
      push(s + PC + k * GC, v, (k < NS - 1), 1'b1);
    end
  endtask

  task automatic drain(input string nm, input int lim);
    int t;
    t = 0;
    while ((exp_q.size() != 0) && (t < lim)) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d edges missing, want 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    mon_en = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    n_cmp += 3;
    if (bus.stage_rst_n !== '0) begin
      n_bad++;
      $display("FAIL rst_rst_n: got %b want 0000", bus.stage_rst_n);
    end
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_busy: got %b want 1", bus.busy);
    end
    if (bus.timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_terr: got %b want 0", bus.timeout_err);
    end
`ifdef RST_CAUSE_EN
    n_cmp++;
    if (bus.rst_cause !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_cause: got %b want 00", bus.rst_cause);
    end
`endif
    prev = bus.stage_rst_n;
    mon_en = 1'b1;
    push_seq(cyc, 1'b0);
    drain("por", 200);
    tick(GC + 2);
    n_cmp += 2;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL por_busy_end: got %b want 0", bus.busy);
    end
    if (bus.timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL por_terr_end: got %b want 0", bus.timeout_err);
    end
  endtask

  task automatic test_ack_late();
    int s;
    bus.stage_ack = 4'b1101;
    s = cyc + 1;
    push(s, 4'b0000, 1'b1, 1'b1);
    push(s + 16, 4'b0001, 1'b1, 1'b1);
    push(s + 24, 4'b0011, 1'b1, 1'b1);
    push(s + 45, 4'b0111, 1'b1, 1'b1);
    push(s + 53, 4'b1111, 1'b0, 1'b0);
    bus.sw_req = 1'b1;
    tick(1);
    bus.sw_req = 1'b0;
    wait_until(s + 44);
    n_cmp++;
    if (bus.stage_rst_n !== 4'b0011) begin
      n_bad++;
      $display("FAIL late_hold: got %b want 0011", bus.stage_rst_n);
    end
    bus.stage_ack[1] = 1'b1;
    drain("late", 200);
    tick(GC + 2);
    n_cmp += 2;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL late_busy: got %b want 0", bus.busy);
    end
    if (bus.timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL late_terr: got %b want 0", bus.timeout_err);
    end
`ifdef RST_CAUSE_EN
    n_cmp++;
    if (bus.rst_cause !== 2'b01) begin
      n_bad++;
      $display("FAIL late_cause: got %b want 01", bus.rst_cause);
    end
`endif
  endtask

  task automatic test_ack_timeout();
    int s;
    bus.stage_ack = 4'b1011;
    s = cyc + 1;
    push(s, 4'b0000, 1'b1, 1'b1);
    push(s + 16, 4'b0001, 1'b1, 1'b1);
    push(s + 24, 4'b0011, 1'b1, 1'b1);
    push(s + 32, 4'b0111, 1'b1, 1'b1);
    push(s + 32 + AT, 4'b1111, 1'b0, 1'b0);
    bus.sw_req = 1'b1;
    tick(1);
    bus.sw_req = 1'b0;
    wait_until(s + 31 + AT);
    n_cmp++;
    if (bus.timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_early: got %b want 0", bus.timeout_err);
    end
    drain("tmo", 200);
    tick(GC + 2);
    n_cmp += 2;
    if (bus.timeout_err !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_terr: got %b want 1", bus.timeout_err);
    end
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_busy: got %b want 0", bus.busy);
    end
    bus.stage_ack = '1;
  endtask

  task automatic test_sw_midrelease();
    int s;
    int s2;
    s = cyc + 1;
    push(s, 4'b0000, 1'b1, 1'b1);
    push(s + 16, 4'b0001, 1'b1, 1'b1);
    push(s + 24, 4'b0011, 1'b1, 1'b1);
    bus.sw_req = 1'b1;
    tick(1);
    bus.sw_req = 1'b0;
    wait_until(s + 24);
    s2 = cyc + 1;
    push_seq(s2, 1'b1);
    bus.sw_req = 1'b1;
    tick(1);
    bus.sw_req = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_busy: got %b want 1", bus.busy);
    end
    drain("mid", 200);
    tick(GC + 2);
    n_cmp += 2;
    if (bus.timeout_err !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_terr_sticky: got %b want 1", bus.timeout_err);
    end
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_busy_end: got %b want 0", bus.busy);
    end
`ifdef RST_CAUSE_EN
    n_cmp++;
    if (bus.rst_cause !== 2'b01) begin
      n_bad++;
      $display("FAIL mid_cause: got %b want 01", bus.rst_cause);
    end
`endif
  endtask

  task automatic test_wdt_hold();
    int s;
    s = cyc + 1;
    push(s, 4'b0000, 1'b1, 1'b1);
    push_seq(s + 44, 1'b0);
    bus.sw_req = 1'b1;
    tick(1);
    bus.sw_req = 1'b0;
    wait_until(s + 4);
    bus.wdt_req = 1'b1;
    wait_until(s + 44);
    bus.wdt_req = 1'b0;
    n_cmp += 2;
    if (bus.stage_rst_n !== 4'b0000) begin
      n_bad++;
      $display("FAIL wdt_hold: got %b want 0000", bus.stage_rst_n);
    end
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL wdt_busy: got %b want 1", bus.busy);
    end
`ifdef RST_CAUSE_EN
    n_cmp++;
    if (bus.rst_cause !== 2'b10) begin
      n_bad++;
      $display("FAIL wdt_cause: got %b want 10", bus.rst_cause);
    end
`endif
    drain("wdt", 200);
    tick(GC + 2);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL wdt_busy_end: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_both_idle();
    int s;
    s = cyc + 1;
    push_seq(s, 1'b1);
    bus.sw_req = 1'b1;
    bus.wdt_req = 1'b1;
    tick(1);
    bus.sw_req = 1'b0;
    bus.wdt_req = 1'b0;
`ifdef RST_CAUSE_EN
    n_cmp++;
    if (bus.rst_cause !== 2'b11) begin
      n_bad++;
      $display("FAIL both_cause: got %b want 11", bus.rst_cause);
    end
`endif
    drain("both", 200);
    tick(GC + 2);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL both_busy_end: got %b want 0", bus.busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, want finish");
    $fatal(1);
  end

  initial begin
    bus.sw_req = 1'b0;
    bus.wdt_req = 1'b0;
    bus.stage_ack = '1;
    test_reset();
    test_ack_late();
    test_ack_timeout();
    test_sw_midrelease();
    test_wdt_hold();
    test_both_idle();
    test_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
